// File: rtl/jump_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : jump_ctrl
// Desc     : Game sequencer for the bounce unit: step divider, jump charge and
//            launch, landing detection, BCD score and lives bookkeeping.
// Options  : AUTO_REBOUND_EN - holding jump at landing chains straight into a
//            new charge without re-homing the bounce unit.
// Revision : 1.0 - initial release
//==============================================================================
module jump_ctrl #(
    parameter int TICK_DIV     = 2500000,
    parameter int MIN_SPEED    = 7,
    parameter int MAX_SPEED    = 13,
    parameter int CHARGE_STEPS = 4,
    parameter int LIVES        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_jump,
    input  logic        hit,
    input  logic [3:0]  b_speed,
    input  logic        b_dir,
    output logic        step,
    output logic        b_start,
    output logic        b_reset,
    output logic [3:0]  max_speed,
    output logic [15:0] score,
    output logic [2:0]  lives,
    output logic [2:0]  state
);

    localparam int                 c_div_w      = $clog2(TICK_DIV);
    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(TICK_DIV - 1);
    localparam logic [15:0]        c_charge_max = 16'((MAX_SPEED - MIN_SPEED) * CHARGE_STEPS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READY  = 3'd1,
        S_CHARGE = 3'd2,
        S_JUMP   = 3'd3,
        S_LAND   = 3'd4,
        S_HURT   = 3'd5,
        S_OVER   = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_div_w-1:0] r_div;
    logic               r_step;
    logic [15:0]        r_charge, w_charge_nxt;
    logic [3:0]         r_max_speed, w_max_speed_nxt;
    logic [15:0]        r_score, w_score_nxt;
    logic [2:0]         r_lives, w_lives_nxt;
    logic               r_b_start;
    logic               r_b_reset, w_b_reset_nxt;
    logic               r_start_q;
    logic               r_arm, w_arm_nxt;
    logic               w_start_rise;
    logic               w_landed;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (res[i*4 +: 4] == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div  <= '0;
            r_step <= 1'b0;
        end else if (r_div == c_div_last) begin
            r_div  <= '0;
            r_step <= 1'b1;
        end else begin
            r_div  <= r_div + 1'b1;
            r_step <= 1'b0;
        end
    end

    assign w_start_rise = btn_start & ~r_start_q;
    assign w_landed     = ~b_dir && (b_speed == 4'd0);

    always_comb begin
        w_state_nxt     = r_state;
        w_charge_nxt    = r_charge;
        w_max_speed_nxt = r_max_speed;
        w_score_nxt     = r_score;
        w_lives_nxt     = r_lives;
        case (r_state)
            S_IDLE: begin
                if (btn_start) begin
                    w_lives_nxt = 3'(LIVES);
                    w_score_nxt = '0;
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (r_step && btn_jump) begin
                    w_charge_nxt = '0;
                    w_state_nxt  = S_CHARGE;
                end
            end
            S_CHARGE: begin
                if (r_step) begin
                    if (btn_jump) begin
                        if (r_charge < c_charge_max)
                            w_charge_nxt = r_charge + 16'd1;
                    end else begin
                        w_max_speed_nxt = 4'(16'(MIN_SPEED) + r_charge / 16'(CHARGE_STEPS));
                        w_state_nxt     = S_JUMP;
                    end
                end
            end
            S_JUMP: begin
                // A collision outranks a landing reported on the same step.
                if (r_step) begin
                    if (hit) begin
                        w_lives_nxt = r_lives - 3'd1;
                        w_state_nxt = S_HURT;
                    end else if (w_landed) begin
                        w_score_nxt = bcd_inc(r_score);
                        w_state_nxt = S_LAND;
                    end
                end
            end
            S_LAND: begin
                if (r_step) begin
`ifdef AUTO_REBOUND_EN
                    if (btn_jump) begin
                        w_charge_nxt = '0;
                        w_state_nxt  = S_CHARGE;
                    end else begin
                        w_state_nxt  = S_READY;
                    end
`else
                    w_state_nxt = S_READY;
`endif
                end
            end
            S_HURT: begin
                if (r_step)
                    w_state_nxt = (r_lives == 3'd0) ? S_OVER : S_READY;
            end
            S_OVER: begin
                if (r_step && (r_arm || w_start_rise))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A press seen between steps while in OVER is remembered until the next step.
    assign w_arm_nxt = (r_state == S_OVER) && (r_arm || w_start_rise);

    // Leaving LAND for READY holds the bounce unit in reset for one step to re-home it.
    always_comb begin
        w_b_reset_nxt = r_b_reset;
        if (r_step || (w_state_nxt != r_state)) begin
            case (w_state_nxt)
                S_READY:                  w_b_reset_nxt = (r_state != S_LAND);
                S_CHARGE, S_JUMP, S_LAND: w_b_reset_nxt = 1'b1;
                default:                  w_b_reset_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_charge    <= '0;
            r_max_speed <= 4'(MIN_SPEED);
            r_score     <= '0;
            r_lives     <= '0;
            r_b_start   <= 1'b0;
            r_b_reset   <= 1'b0;
            r_start_q   <= 1'b0;
            r_arm       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_charge    <= w_charge_nxt;
            r_max_speed <= w_max_speed_nxt;
            r_score     <= w_score_nxt;
            r_lives     <= w_lives_nxt;
            r_b_start   <= (w_state_nxt == S_JUMP);
            r_b_reset   <= w_b_reset_nxt;
            r_start_q   <= btn_start;
            r_arm       <= w_arm_nxt;
        end
    end

    assign step      = r_step;
    assign b_start   = r_b_start;
    assign b_reset   = r_b_reset;
    assign max_speed = r_max_speed;
    assign score     = r_score;
    assign lives     = r_lives;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
Game-level sequencer for the vertical jump datapath (the bounce unit). It owns the bounce unit's start and active-low reset lines and its max_speed configuration. It charges jump strength from the jump button, launches the jump, detects landing from the bounce unit's speed/direction feedback, and maintains score and lives. It sits between the debounced board buttons and the bounce instance; score and lives feed the seven-segment and VGA overlay logic.

Parameters:
TICK_DIV, 2500000, clk cycles per physics step (step strobe period); must be >= 2
MIN_SPEED, 7, max_speed value for a zero-charge jump; range 7..14
MAX_SPEED, 13, saturation value for charged max_speed; MIN_SPEED <= MAX_SPEED <= 14
CHARGE_STEPS, 4, physics steps of button hold per +1 max_speed
LIVES, 3, lives loaded at game start; range 1..7

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_start  in  1  debounced, synchronous level; new game / leave OVER
btn_jump  in  1  debounced, synchronous level; hold to charge, release to launch
hit  in  1  collision level from renderer; sampled on step only
b_speed  in  4  speed output of the bounce unit
b_dir  in  1  direction output of the bounce unit (1 = rising)
step  out  1  one-clk strobe every TICK_DIV cycles; advances the bounce unit
b_start  out  1  bounce unit start
b_reset  out  1  bounce unit reset, active-low
max_speed  out  4  launch strength to the bounce unit
score  out  16  4-digit BCD jump count
lives  out  3  remaining lives
state  out  3  encoded FSM state for debug/overlay

Behaviour:
- Reset (reset=0, async): state=IDLE, step=0, b_start=0, b_reset=0, max_speed=MIN_SPEED, score=0, lives=0, divider=0, charge counter=0.
- Divider: counts 0..TICK_DIV-1 continuously. step=1 for exactly one clk when the count wraps. All FSM transitions except IDLE->READY occur only on step cycles.
- States (encoding): IDLE=0, READY=1, CHARGE=2, JUMP=3, LAND=4, HURT=5, OVER=6.
- IDLE: b_reset=0, b_start=0. On btn_start (any cycle): lives<=LIVES, score<=0, go READY.
- READY: b_reset=1, b_start=0. On step with btn_jump=1: charge counter<=0, go CHARGE.
- CHARGE: on each step with btn_jump=1, charge counter +1, saturating at (MAX_SPEED-MIN_SPEED)*CHARGE_STEPS. On step with btn_jump=0: max_speed<=MIN_SPEED+charge/CHARGE_STEPS, then go JUMP.
- JUMP: b_start=1. max_speed is held constant for the whole jump.
  - On step with hit=1: go HURT. Hit has priority over landing on the same step.
  - Else on step with b_dir=0 and b_speed=0 (bounce has returned to ground): go LAND.
- LAND: one step long. b_start=0. score BCD +1; 9999 wraps to 0000. Then b_reset=0 for this step to re-home the bounce unit, and go READY.
- HURT: one step long. b_start=0, b_reset=0. lives-1. If the result is 0, go OVER; else go READY.
- OVER: b_start=0, b_reset=0. Score and lives are frozen. A btn_start rising edge (registered previous level) goes to IDLE. A btn_start held high through the OVER entry does not restart.
- b_reset and b_start are registered outputs. b_reset=0 is never asserted together with b_start=1.
- btn_jump pressed during JUMP, LAND or HURT is ignored. Charge starts only from READY.

Optional Feature:
AUTO_REBOUND_EN
- Defined: in LAND, if btn_jump=1, the score still increments and the FSM goes directly to CHARGE. b_reset is not pulsed; charge counter<=0. This allows chained jumps.
- Undefined: LAND always re-homes the bounce unit and returns to READY, as specified above.

Test Plan:
- TICK_DIV=4, reset low then high -> step pulses every 4th clk; state=IDLE, b_reset=0, lives=0, score=0000.
- btn_start, then btn_jump held 8 steps and released (CHARGE_STEPS=4) -> max_speed=9, JUMP entered, b_start=1 on the next clk.
- Drive b_dir=0, b_speed=0 on a JUMP step -> LAND for one step, score=0001, then READY with one step of b_reset=0.
- hit=1 together with the landing condition on the same step -> HURT, lives 3->2, score unchanged.
- Three hurts -> OVER, lives=0. btn_start held across the OVER entry does not restart; release then press -> IDLE.
- Score preset to 9999 via 9999 landings (or force) plus one more landing -> 0000. With AUTO_REBOUND_EN and btn_jump held at LAND -> CHARGE, no b_reset pulse.
